cc_tag_filter_assoc: RTL

- Parametrised set-associative coherence tag filter for the L1/L2 interface, successor to the single-way-per-instance tag filter.
- Holds WAYS ways internally and serves RPORTS parallel snoop lookups.
- Takes one allocate/invalidate request at a time.
- Selects victims by NRU with invalid-first priority and issues evicted addresses over a valid/ready handshake.
- Runs its own init sweep after reset or on request.

---
 rtl/cc_pkg.sv | 25 ++
 rtl/cc_nru_set.sv | 27 ++
 rtl/cc_tag_filter_assoc.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/cc_pkg.sv
// Shared definitions for the set-associative coherence tag filter: entry layout,
// controller states and small helpers used by the filter and its NRU logic.
package cc_pkg;

  // Entry is {parity, valid, tag}; these offsets sit above the TAG_W-bit tag field.
  localparam int VALID_OFS  = 0;
  localparam int PARITY_OFS = 1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_LOOK,
    ST_EVICT
  } state_t;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_par(input logic [63:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/cc_nru_set.sv
// Per-set NRU vector update and victim pick (lowest way whose NRU bit is clear).
module cc_nru_set
  import cc_pkg::*;
#(
  parameter  int WAYS = 4,
  localparam int IW   = idx_w(WAYS)
) (
  input  logic [WAYS-1:0] old_vec,
  input  logic [WAYS-1:0] set_bits,
  output logic [WAYS-1:0] new_vec,
  output logic [IW-1:0]   victim
);

  always_comb begin
    new_vec = old_vec | set_bits;
    if (set_bits != '0) begin
      if (&set_bits)
        new_vec = {{(WAYS-1){1'b0}}, 1'b1};
      else if (&new_vec)
        new_vec = set_bits;
    end
    victim = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!old_vec[w]) victim = IW'(w);
  end

endmodule

// File: rtl/cc_tag_filter_assoc.sv
// Set-associative coherence tag filter: RPORTS parallel snoop lookups, one
// allocate/invalidate at a time, NRU victims evicted over a valid/ready handshake.
module cc_tag_filter_assoc
  import cc_pkg::*;
#(
  parameter  int WAYS     = 4,
  parameter  int SET_BITS = 6,
  parameter  int TAG_W    = 37,
  parameter  int RPORTS   = 4,
  localparam int IW       = idx_w(WAYS)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          init,
  output logic                          init_busy,
  input  logic [RPORTS-1:0]             rd_en,
  input  logic [RPORTS-1:0][TAG_W-1:0]  rd_paddr,
  output logic [RPORTS-1:0]             rd_hit,
  output logic [RPORTS-1:0][IW-1:0]     rd_way,
  output logic [RPORTS-1:0]             rd_err,
  input  logic                          wr_en,
  input  logic                          wr_inval,
  input  logic [TAG_W-1:0]              wr_paddr,
  output logic                          wr_ready,
  output logic                          ev_valid,
  output logic [TAG_W-1:0]              ev_paddr,
  input  logic                          ev_ready
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int ENT_W = TAG_W + 2;
  localparam int VB    = TAG_W + VALID_OFS;

  logic [ENT_W-1:0]    mem [SETS][WAYS];
  logic [WAYS-1:0]     nru [SETS];
  state_t              state, state_nx;
  logic [SET_BITS-1:0] cnt;
  logic                req_inval;
  logic [TAG_W-1:0]    req_paddr;
  logic [IW-1:0]       vic_way;

  function automatic logic [ENT_W-1:0] make_entry(input logic v, input logic [TAG_W-1:0] t);
    return {even_par(64'({v, t})), v, t};
  endfunction

  // Lookup stage: compare against pre-edge array contents, results registered at the edge.
  logic [RPORTS-1:0][WAYS-1:0] rhit, rerr;
  logic [RPORTS-1:0][IW-1:0]   rway_nx;

  always_comb begin
    logic [ENT_W-1:0] e;
    logic             good;
    e       = '0;
    good    = 1'b0;
    rhit    = '0;
    rerr    = '0;
    rway_nx = '0;
    for (int p = 0; p < RPORTS; p++) begin
      for (int w = 0; w < WAYS; w++) begin
        e    = mem[rd_paddr[p][SET_BITS-1:0]][w];
        good = ((^e) == 1'b0);
        rhit[p][w] = rd_en[p] && (state != ST_INIT) && good && e[VB] &&
                     (e[TAG_W-1:0] == rd_paddr[p]);
        rerr[p][w] = rd_en[p] && (state != ST_INIT) && !good;
      end
      for (int w = WAYS - 1; w >= 0; w--)
        if (rhit[p][w]) rway_nx[p] = IW'(w);
    end
  end

  always_ff @(negedge clk) begin
    if (rst) begin
      rd_hit <= '0;
      rd_way <= '0;
      rd_err <= '0;
    end else begin
      for (int p = 0; p < RPORTS; p++) begin
        rd_hit[p] <= |rhit[p];
        rd_err[p] <= |rerr[p];
      end
      rd_way <= rway_nx;
    end
  end

  // Request-side compare of the latched address against its set.
  logic [SET_BITS-1:0] lk_set;
  logic [WAYS-1:0]     lk_hit, lk_inv;
  logic [IW-1:0]       lk_hit_way, lk_inv_way;

  assign lk_set = req_paddr[SET_BITS-1:0];

  always_comb begin
    logic [ENT_W-1:0] e;
    e          = '0;
    lk_hit     = '0;
    lk_inv     = '0;
    lk_hit_way = '0;
    lk_inv_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      e = mem[lk_set][w];
      lk_hit[w] = ((^e) == 1'b0) && e[VB] && (e[TAG_W-1:0] == req_paddr);
      lk_inv[w] = !e[VB];
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (lk_hit[w]) lk_hit_way = IW'(w);
      if (lk_inv[w]) lk_inv_way = IW'(w);
    end
  end

  // NRU: merge all read hits and the request-side set bits per set.
  logic [WAYS-1:0] wset, wclr;
  logic [WAYS-1:0] nru_set_in [SETS];
  logic [WAYS-1:0] nru_new    [SETS];
  logic [IW-1:0]   nru_vic    [SETS];

  always_comb begin
    for (int s = 0; s < SETS; s++) begin
      nru_set_in[s] = (lk_set == SET_BITS'(s)) ? wset : '0;
      for (int p = 0; p < RPORTS; p++)
        if (rd_paddr[p][SET_BITS-1:0] == SET_BITS'(s)) nru_set_in[s] = nru_set_in[s] | rhit[p];
    end
  end

  for (genvar s = 0; s < SETS; s++) begin : g_nru
    cc_nru_set #(.WAYS(WAYS)) u_nru (
      .old_vec  (nru[s]),
      .set_bits (nru_set_in[s]),
      .new_vec  (nru_new[s]),
      .victim   (nru_vic[s])
    );
  end

  // Controller
  logic             arr_we;
  logic [IW-1:0]    arr_way, alloc_way;
  logic [ENT_W-1:0] arr_data;

  always_ff @(negedge clk) begin
    if (rst) state <= ST_INIT;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    wr_ready  = 1'b0;
    ev_valid  = 1'b0;
    init_busy = 1'b0;
    arr_we    = 1'b0;
    arr_way   = '0;
    arr_data  = '0;
    wset      = '0;
    wclr      = '0;
    alloc_way = (|lk_inv) ? lk_inv_way : nru_vic[lk_set];
    case (state)
      ST_INIT: begin
        init_busy = 1'b1;
        if (cnt == SET_BITS'(SETS - 1)) state_nx = ST_IDLE;
      end
      ST_IDLE: begin
        wr_ready = 1'b1;
        // An accepted request wins over a same-cycle init request.
        if (wr_en)     state_nx = ST_LOOK;
        else if (init) state_nx = ST_INIT;
      end
      ST_LOOK: begin
        state_nx = ST_IDLE;
        if (|lk_hit) begin
          if (req_inval) begin
            arr_we   = 1'b1;
            arr_way  = lk_hit_way;
            arr_data = make_entry(1'b0, req_paddr);
            wclr     = WAYS'(1) << lk_hit_way;
          end else begin
            wset = WAYS'(1) << lk_hit_way;
          end
        end else if (!req_inval) begin
          if (|lk_inv) begin
            arr_we   = 1'b1;
            arr_way  = alloc_way;
            arr_data = make_entry(1'b1, req_paddr);
            wset     = WAYS'(1) << alloc_way;
          end else begin
            state_nx = ST_EVICT;
          end
        end
      end
      ST_EVICT: begin
        ev_valid = 1'b1;
        if (ev_ready) begin
          arr_we   = 1'b1;
          arr_way  = vic_way;
          arr_data = make_entry(1'b1, req_paddr);
          wset     = WAYS'(1) << vic_way;
          state_nx = ST_IDLE;
        end
      end
      default: state_nx = ST_INIT;
    endcase
  end

  // Array, NRU and sweep counter
  always_ff @(negedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == ST_INIT) begin
      for (int w = 0; w < WAYS; w++) mem[cnt][w] <= '0;
      nru[cnt] <= '0;
      cnt      <= cnt + 1'b1;
    end else begin
      if (state == ST_IDLE && !wr_en && init) cnt <= '0;
      for (int s = 0; s < SETS; s++)
        nru[s] <= nru_new[s] & ~((lk_set == SET_BITS'(s)) ? wclr : '0);
      if (arr_we) mem[lk_set][arr_way] <= arr_data;
    end
  end

  always_ff @(negedge clk) begin
    if (state == ST_IDLE && wr_en) begin
      req_inval <= wr_inval;
      req_paddr <= wr_paddr;
    end
    if (state == ST_LOOK) vic_way <= alloc_way;
  end

  always_ff @(negedge clk) begin
    if (rst)
      ev_paddr <= '0;
    else if (state == ST_LOOK && state_nx == ST_EVICT)
      ev_paddr <= mem[lk_set][alloc_way][TAG_W-1:0];
  end

endmodule
